// File: rtl/shift_r_seq.sv
// ============================================================================
// shift_r_seq -- sequential right-shift unit for the 16-bit datapath
//
// Serves the ALU srl / sra (and optionally ror) instructions.  The operand is
// shifted one bit position per clock under a start/busy/done handshake with
// the control FSM.  The unit returns the result and the last bit shifted out,
// which is used for flag generation.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request a shift; sampled only in IDLE
//   op     in   2      00 logical, 01 arithmetic, 10 rotate (optional), 11 = 00
//   in     in   WIDTH  operand, sampled with start
//   amt    in   4      shift amount 0..15, sampled with start
//   out    out  WIDTH  result register, updated only when an operation completes
//   cout   out  1      last bit shifted out, updated together with out
//   busy   out  1      high while the FSM is not IDLE
//   done   out  1      one-cycle pulse while the result is freshly valid
//
// Configuration macro
//   SHIFTR_ROTATE_EN  defined  : op=10 rotates right (fill = sh[0])
//                     undefined: op=10 shifts logically (fill = 0) and no
//                                rotate fill logic is built
//
// Timing: start edge E0, amt shift edges E1..Eamt, edge Eamt+1 writes out/cout
// and enters DONE.  A new start is accepted one IDLE cycle after DONE.
// ============================================================================
module shift_r_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in,
   input  logic [3:0]       amt,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   // Operation encodings as held in op_reg
   localparam logic [1:0] OP_SRA = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] sh_reg;     // working copy of the operand
   logic [3:0]       cnt_reg;    // remaining shift positions
   logic [1:0]       op_reg;     // operation captured at start
   logic             cout_reg;   // running carry-out, published at completion
   logic             fill;       // bit entering at the MSB on each shift

   // Fill bit selection.  op=11 and (without rotate support) op=10 both fall
   // through to the logical fill of zero.
   always_comb begin
      fill = 1'b0;
      case (op_reg)
         OP_SRA:  fill = sh_reg[WIDTH-1];
`ifdef SHIFTR_ROTATE_EN
         OP_ROR:  fill = sh_reg[0];
`else
         OP_ROR:  fill = 1'b0;
`endif
         default: fill = 1'b0;
      endcase
   end

   // Control FSM and datapath registers.  out/cout are only written on the
   // SHIFT->DONE transition, so they keep the previous result while a new
   // operation is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         sh_reg    <= '0;
         cnt_reg   <= '0;
         op_reg    <= '0;
         cout_reg  <= 1'b0;
         out       <= '0;
         cout      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  sh_reg    <= in;
                  cnt_reg   <= amt;
                  op_reg    <= op;
                  cout_reg  <= 1'b0;
                  state_reg <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               // Decrement only while non-zero, so cnt_reg cannot wrap.
               if (cnt_reg != 4'd0) begin
                  cout_reg <= sh_reg[0];
                  cnt_reg  <= cnt_reg - 4'd1;
                  sh_reg   <= {fill, sh_reg[WIDTH-1:1]};
               end else begin
                  out       <= sh_reg;
                  cout      <= cout_reg;
                  state_reg <= ST_DONE;
               end
            end

            ST_DONE: begin
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Status decoded straight from the state register: no input reaches these
   // outputs combinationally.
   assign busy = (state_reg != ST_IDLE);
   assign done = (state_reg == ST_DONE);

endmodule
